// File: rtl/mm2s_if.sv
// Command/status, AXI-MM read and AXI-Stream signals of the MM2S read engine.
// master = engine side, slave = memory/stream/command environment side.
interface mm2s_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 23
) ();
  localparam int BYTES = DATA_W / 8;

  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              sts_valid;
  logic              sts_error;

  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic              m_axi_rlast;

  logic [DATA_W-1:0] m_axis_tdata;
  logic [BYTES-1:0]  m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport master (
    input  cmd_addr, cmd_len, cmd_valid,
    output cmd_ready, sts_valid, sts_error,
    output m_axi_araddr, m_axi_arlen, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axi_rlast,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    output cmd_addr, cmd_len, cmd_valid,
    input  cmd_ready, sts_valid, sts_error,
    input  m_axi_araddr, m_axi_arlen, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axi_rlast,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/mm2s_engine.sv
// Memory-to-stream DMA read engine: splits a byte-length command into 4KB-safe
// AXI read bursts, buffers the returned data and emits one AXIS packet per command.
module mm2s_engine #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 23,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_OUTST  = 4
) (
  input logic   clk,
  input logic   rst,
  mm2s_if.master bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int LOG_B = $clog2(BYTES);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int OW    = $clog2(MAX_OUTST + 1);
  localparam int BW    = $clog2(MAX_BURST + 1);
  localparam int MW    = (LEN_W > 13) ? LEN_W : 13;
  localparam int SW    = CW + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, STATUS} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q, araddr_q;
  logic [7:0]        arlen_q;
  logic              arvalid_q;
  logic [LEN_W-1:0]  rem_beats, total_beats, ld_cnt;
  logic [LOG_B-1:0]  len_tail;
  logic [BW-1:0]     burst_beats, next_beats;
  logic [OW-1:0]     outst;
  logic [CW-1:0]     in_flight, fifo_cnt;
  logic              err_q;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] data_p1;
  logic [BYTES-1:0]  keep_p1;
  logic              last_p1, vld_p1;

  logic [12:0]       to_4k;
  logic [MW-1:0]     beats_m;
  logic [LEN_W:0]    len_up;
  logic [LEN_W-1:0]  cmd_beats;
  logic              credit_ok, can_issue, ar_hs, r_hs, pop, resp_err, rready;

  function automatic logic [BYTES-1:0] last_keep(input logic [LOG_B-1:0] tail);
    last_keep = (tail == '0) ? {BYTES{1'b1}} : ~({BYTES{1'b1}} << tail);
  endfunction

  assign rready    = (state == ISSUE) || (state == DRAIN);
  assign ar_hs     = arvalid_q && bus.m_axi_arready;
  assign r_hs      = bus.m_axi_rvalid && rready;
  assign pop       = (fifo_cnt != '0) && (!vld_p1 || bus.m_axis_tready);
  assign resp_err  = (bus.m_axi_rresp == 2'b10) || (bus.m_axi_rresp == 2'b11);
  assign len_up    = {1'b0, bus.cmd_len} + (LEN_W+1)'(BYTES - 1);
  assign cmd_beats = LEN_W'(len_up >> LOG_B);

  // Next burst size: remaining beats, capped by MAX_BURST and the 4KB page end.
  always_comb begin
    to_4k   = 13'd4096 - {1'b0, addr_q[11:0]};
    beats_m = MW'(MAX_BURST);
    if (MW'(rem_beats) < beats_m) beats_m = MW'(rem_beats);
    if (MW'(to_4k >> LOG_B) < beats_m) beats_m = MW'(to_4k >> LOG_B);
    next_beats = BW'(beats_m);
    credit_ok  = (SW'(fifo_cnt) + SW'(in_flight) + SW'(next_beats)) <= SW'(FIFO_DEPTH);
    can_issue  = (state == ISSUE) && !arvalid_q && (rem_beats != '0) &&
                 (outst < OW'(MAX_OUTST)) && credit_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      rem_beats   <= '0;
      total_beats <= '0;
      len_tail    <= '0;
      burst_beats <= '0;
      outst       <= '0;
      in_flight   <= '0;
      err_q       <= 1'b0;
    end else begin
      if (r_hs && resp_err) err_q <= 1'b1;
      case ({ar_hs, r_hs && bus.m_axi_rlast})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: ;
      endcase
      in_flight <= in_flight + (ar_hs ? CW'(burst_beats) : '0) - (r_hs ? CW'(1) : '0);
      case (state)
        IDLE: if (bus.cmd_valid) begin
          addr_q      <= bus.cmd_addr & ~ADDR_W'(BYTES - 1);
          total_beats <= cmd_beats;
          rem_beats   <= cmd_beats;
          len_tail    <= bus.cmd_len[LOG_B-1:0];
          state       <= (bus.cmd_len == '0) ? STATUS : ISSUE;
        end
        ISSUE: begin
          if (can_issue) begin
            arvalid_q   <= 1'b1;
            araddr_q    <= addr_q;
            arlen_q     <= 8'(next_beats - BW'(1));
            burst_beats <= next_beats;
          end
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            addr_q    <= addr_q + (ADDR_W'(burst_beats) << LOG_B);
            rem_beats <= rem_beats - LEN_W'(burst_beats);
            if (rem_beats == LEN_W'(burst_beats)) state <= DRAIN;
          end
        end
        DRAIN: if (outst == '0 && fifo_cnt == '0 && !vld_p1) state <= STATUS;
        STATUS: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_hs) mem[wr_ptr] <= bus.m_axi_rdata;
  end

  // Stage p1: FIFO head registered onto the stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ld_cnt   <= '0;
      data_p1  <= '0;
      keep_p1  <= '0;
      last_p1  <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      if (r_hs) wr_ptr <= wr_ptr + AW'(1);
      case ({r_hs, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        data_p1 <= mem[rd_ptr];
        vld_p1  <= 1'b1;
        last_p1 <= (ld_cnt == total_beats - LEN_W'(1));
        keep_p1 <= (ld_cnt == total_beats - LEN_W'(1)) ? last_keep(len_tail) : {BYTES{1'b1}};
      end else if (bus.m_axis_tready) begin
        vld_p1 <= 1'b0;
      end
      if (state == IDLE)  ld_cnt <= '0;
      else if (pop)       ld_cnt <= ld_cnt + LEN_W'(1);
    end
  end

  assign bus.cmd_ready     = (state == IDLE);
  assign bus.sts_valid     = (state == STATUS);
  assign bus.sts_error     = (state == STATUS) && err_q;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready;
  assign bus.m_axis_tdata  = data_p1;
  assign bus.m_axis_tkeep  = keep_p1;
  assign bus.m_axis_tvalid = vld_p1;
  assign bus.m_axis_tlast  = last_p1;
endmodule
